// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding and bit-period arithmetic.
// Pure declarations, no latency; no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int bit_clks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte-side and line-side signals of the UART receiver.
// No latency; no backpressure, rec_dout is a level that holds the last good byte.
interface uart_rx_core_if;
    logic       rec_en;
    logic       rec_din;
    logic [7:0] rec_dout;
    logic       rec_busy;

    modport master (output rec_en, output rec_din, input rec_dout, input rec_busy);
    modport slave  (input rec_en, input rec_din, output rec_dout, output rec_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// 2-FF synchroniser plus delay flop for an async serial line; flags falling edges.
// line is 2 clocks behind din, fall 2 clocks behind the edge; no backpressure.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic line,
    output logic fall
);

    logic meta_q;
    logic cur_q;
    logic prev_q;

    // Flops reset to the idle-high level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            cur_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            cur_q  <= meta_q;
            prev_q <= cur_q;
        end
    end

    assign line = cur_q;
    assign fall = prev_q & ~cur_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling, byte presented on rec_dout after a good stop bit.
// rec_dout updates ~9.5 bit times + 3 clocks after the start edge; no backpressure.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 64_935
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    uart_rx_core_if.slave  rx
);

    localparam int BIT_CLKS = bit_clks(CLK_FREQ, BAUD_RATE);
    localparam int CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] MID_CNT  = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CLKS - 1);

    logic line;
    logic fall;

    uart_rx_sync u_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (rx.rec_din),
        .line (line),
        .fall (fall)
    );

    rx_state_t              state;
    logic [CW-1:0]          clk_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   dout_q;
    logic                   busy_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx.rec_en && fall) begin
                        state   <= START;
                        clk_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    // Restarting the count at the start-bit centre aligns all later samples to bit centres.
                    if (clk_cnt == MID_CNT) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (!line) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt        <= '0;
                        shreg[bit_cnt] <= line;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit is a framing error: drop the byte, keep the previous one.
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        if (line) begin
                            dout_q <= shreg;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rec_dout = dout_q;
    assign rx.rec_busy = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised scoreboard bench for uart_rx_core at default parameters (25 MHz, 385 clocks per bit).
module tb_uart_rx_core;

    localparam int CLK_NS   = 40;
    localparam int BIT_CLKS = 25_000_000 / 64_935;
    localparam int BIT_NS   = BIT_CLKS * CLK_NS;
    // Start edge to busy drop: half a bit to the start centre, then nine whole bits to the stop centre.
    localparam int BUSY_LEN = BIT_CLKS / 2 + 9 * BIT_CLKS;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always #(CLK_NS / 2) sys_clk = ~sys_clk;

    uart_rx_core_if rx_if ();

    uart_rx_core dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx_if)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         busy_rises = 0;
    int         rise_cyc = 0;
    int         last_busy_len = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] model_dout = 8'h00;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed busy pulse must match the oldest expected rec_dout.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                if (!prev_busy && rx_if.rec_busy) begin
                    busy_rises++;
                    rise_cyc = cyc;
                end
                if (prev_busy && !rx_if.rec_busy) begin
                    last_busy_len = cyc - rise_cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_frame: busy pulse with rec_dout=0x%0h, no frame expected",
                                 rx_if.rec_dout);
                    end else begin
                        check("sb_rec_dout", 32'(rx_if.rec_dout), 32'(exp_q.pop_front()));
                    end
                end
            end
            prev_busy = rx_if.rec_busy;
        end
    end

    // en_mode: 0 enabled throughout, 1 enable drops after bit 2, 2 disabled throughout.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int en_mode, input int gap_bits);
        int gap;
        gap = (!stop && gap_bits < 1) ? 1 : gap_bits;
        if (en_mode != 2) begin
            if (stop) model_dout = b;
            exp_q.push_back(model_dout);
        end
        rx_if.rec_en  = (en_mode != 2);
        rx_if.rec_din = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_if.rec_din = b[i];
            if (en_mode == 1 && i == 2) rx_if.rec_en = 1'b0;
            #(BIT_NS);
        end
        rx_if.rec_din = stop;
        #(BIT_NS);
        rx_if.rec_din = 1'b1;
        #(gap * BIT_NS);
    endtask

    initial begin
        int r0;
        int c0;
        int bound;
        logic [7:0] b;
        int sel;
        int mode;
        logic stop;

        rx_if.rec_en  = 1'b0;
        rx_if.rec_din = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_dout", 32'(rx_if.rec_dout), 32'h00);
        check("rst_busy", 32'(rx_if.rec_busy), 32'h0);
        sys_rst = 1'b0;

        #20000;
        check("idle_no_busy", 32'(busy_rises), 32'd0);

        send_frame(8'h55, 1'b1, 0, 1);
        check("busy_len_55", 32'(last_busy_len >= BUSY_LEN - 3 && last_busy_len <= BUSY_LEN + 4), 32'd1);

        r0 = busy_rises;
        send_frame(8'hA3, 1'b1, 0, 0);
        send_frame(8'h0F, 1'b1, 0, 1);
        check("b2b_pulses", 32'(busy_rises - r0), 32'd2);
        check("b2b_dout", 32'(rx_if.rec_dout), 32'(model_dout));

        r0 = busy_rises;
        send_frame(8'hFF, 1'b1, 2, 1);
        check("dis_no_busy", 32'(busy_rises - r0), 32'd0);
        check("dis_dout_hold", 32'(rx_if.rec_dout), 32'(model_dout));

        // 3 us glitch: start is rejected at the half-bit check, well inside 8 us.
        rx_if.rec_en = 1'b1;
        exp_q.push_back(model_dout);
        r0 = busy_rises;
        @(posedge sys_clk);
        #1;
        c0 = cyc;
        rx_if.rec_din = 1'b0;
        #3000;
        rx_if.rec_din = 1'b1;
        while (cyc < c0 + 200) @(posedge sys_clk);
        @(negedge sys_clk);
        check("glitch_busy_rose", 32'(busy_rises - r0), 32'd1);
        check("glitch_busy_dropped", 32'(rx_if.rec_busy), 32'd0);
        #(BIT_NS);

        send_frame(8'h3C, 1'b0, 0, 2);
        check("ferr_dout_hold", 32'(rx_if.rec_dout), 32'(model_dout));

        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            sel  = $urandom_range(0, 9);
            mode = (sel <= 6) ? 0 : (sel <= 8) ? 1 : 2;
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, mode, $urandom_range(0, 2));
        end

        bound = 0;
        while (exp_q.size() != 0 && bound < 1000) begin
            @(posedge sys_clk);
            bound++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame clears outputs without waiting for a clock.
        send_frame(8'hC6, 1'b1, 0, 1);
        rx_if.rec_din = 1'b0;
        #(3 * BIT_NS);
        @(posedge sys_clk);
        #7;
        check("pre_rst_busy", 32'(rx_if.rec_busy), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("arst_dout", 32'(rx_if.rec_dout), 32'h00);
        check("arst_busy", 32'(rx_if.rec_busy), 32'd0);
        rx_if.rec_din = 1'b1;
        repeat (10) @(posedge sys_clk);
        #3;
        sys_rst    = 1'b0;
        model_dout = 8'h00;
        #(BIT_NS);

        send_frame(8'h81, 1'b1, 0, 1);
        check("post_rst_dout", 32'(rx_if.rec_dout), 32'h81);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
